// File: rtl/matrix_job_scheduler.sv
// matrix_job_scheduler: queues matrix-multiply job descriptors, checks their
// dimensions, launches them one at a time on the matrix engine, watches for
// done or timeout, and returns a completion record per job.
// Optional build macro: MATRIX_SCHED_PERF_EN (per-job RUN cycle count on cpl_cycles).
module matrix_job_scheduler #(
   parameter int QUEUE_DEPTH    = 4,
   parameter int ADDR_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int DIM_ALIGN      = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            job_valid,
   output logic                            job_ready,
   input  logic [7:0]                      job_id,
   input  logic [ADDR_WIDTH-1:0]           job_a_addr,
   input  logic [ADDR_WIDTH-1:0]           job_b_addr,
   input  logic [ADDR_WIDTH-1:0]           job_c_addr,
   input  logic [31:0]                     job_m,
   input  logic [31:0]                     job_n,
   input  logic [31:0]                     job_k,
   output logic                            eng_start,
   output logic                            eng_abort,
   output logic [ADDR_WIDTH-1:0]           eng_a_addr,
   output logic [ADDR_WIDTH-1:0]           eng_b_addr,
   output logic [ADDR_WIDTH-1:0]           eng_c_addr,
   output logic [31:0]                     eng_m,
   output logic [31:0]                     eng_n,
   output logic [31:0]                     eng_k,
   input  logic                            eng_done,
   output logic                            cpl_valid,
   input  logic                            cpl_ready,
   output logic [7:0]                      cpl_id,
   output logic [1:0]                      cpl_status,
   output logic [31:0]                     cpl_cycles,
   output logic [$clog2(QUEUE_DEPTH):0]    queue_level,
   output logic [31:0]                     jobs_completed
);

   localparam int          PW       = $clog2(QUEUE_DEPTH);
   localparam int          LW       = PW + 1;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] ALIGN    = 32'(DIM_ALIGN);
   localparam logic [1:0]  ST_OK    = 2'd0;
   localparam logic [1:0]  ST_BAD   = 2'd1;
   localparam logic [1:0]  ST_TMO   = 2'd2;

   typedef struct packed {
      logic [7:0]            id;
      logic [ADDR_WIDTH-1:0] a;
      logic [ADDR_WIDTH-1:0] b;
      logic [ADDR_WIDTH-1:0] c;
      logic [31:0]           m;
      logic [31:0]           n;
      logic [31:0]           k;
   } job_t;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LAUNCH, S_RUN, S_CPL} state_t;

   state_t        state_q, state_d;
   job_t          fifo_q [QUEUE_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   job_t          cur;
   logic [31:0]   timer;
   logic [1:0]    status;
   logic          push, pop, bad_dim, run_exit, cpl_hs;

   assign job_ready = (level != LW'(QUEUE_DEPTH));
   assign push      = job_valid && job_ready;
   assign pop       = (state_q == S_IDLE) && (level != '0);
   assign cpl_hs    = (state_q == S_CPL) && cpl_ready;
   // A done in the timeout cycle still counts as success.
   assign run_exit  = eng_done || (timer == TMO_LAST);
   assign bad_dim   = (cur.m == '0) || ((cur.m % ALIGN) != '0) ||
                      (cur.n == '0) || ((cur.n % ALIGN) != '0) ||
                      (cur.k == '0) || ((cur.k % ALIGN) != '0);

   // Descriptor storage; emptiness is tracked by the pointers, so no reset here.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr] <= '{job_id, job_a_addr, job_b_addr, job_c_addr, job_m, job_n, job_k};
   end

   // FIFO pointers and occupancy; push and pop together leave level unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Job sequencing state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (level != '0) state_d = S_CHECK;
         S_CHECK:  state_d = bad_dim ? S_CPL : S_LAUNCH;
         S_LAUNCH: state_d = S_RUN;
         S_RUN:    if (run_exit) state_d = S_CPL;
         S_CPL:    if (cpl_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Working job, run timer, completion status and the accepted-completion count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur            <= '0;
         timer          <= '0;
         status         <= ST_OK;
         jobs_completed <= '0;
      end else begin
         if (pop) cur <= fifo_q[rd_ptr];
         if (state_q == S_CHECK && bad_dim) status <= ST_BAD;
         if (state_q == S_LAUNCH) timer <= '0;
         if (state_q == S_RUN) begin
            timer <= timer + 32'd1;
            if (eng_done)                  status <= ST_OK;
            else if (timer == TMO_LAST)    status <= ST_TMO;
         end
         if (cpl_hs) jobs_completed <= jobs_completed + 32'd1;
      end
   end

`ifdef MATRIX_SCHED_PERF_EN
   logic [31:0] cyc_q;
   // RUN-cycle count for the job in flight, saturating; bad-dimension jobs keep 0.
   always_ff @(posedge clk) begin
      if (rst)                      cyc_q <= '0;
      else if (state_q == S_CHECK)  cyc_q <= '0;
      else if (state_q == S_RUN)    cyc_q <= (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;
   end
   assign cpl_cycles = cyc_q;
`else
   assign cpl_cycles = '0;
`endif

   assign eng_start   = (state_q == S_LAUNCH);
   assign eng_abort   = (state_q == S_RUN) && !eng_done && (timer == TMO_LAST);
   assign eng_a_addr  = cur.a;
   assign eng_b_addr  = cur.b;
   assign eng_c_addr  = cur.c;
   assign eng_m       = cur.m;
   assign eng_n       = cur.n;
   assign eng_k       = cur.k;
   assign cpl_valid   = (state_q == S_CPL);
   assign cpl_id      = cur.id;
   assign cpl_status  = status;
   assign queue_level = level;

endmodule

// File: tb/tb_matrix_job_scheduler.sv
// Bench for matrix_job_scheduler: directed jobs, an engine responder driven by a
// per-job done-delay plan, and a job-level model checked every cycle.
module tb_matrix_job_scheduler;

   localparam int QD  = 4;
   localparam int AW  = 64;
   localparam int TMO = 128;
   localparam int DA  = 8;
`ifdef MATRIX_SCHED_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk, rst;
   logic          job_valid, job_ready;
   logic [7:0]    job_id;
   logic [AW-1:0] job_a_addr, job_b_addr, job_c_addr;
   logic [31:0]   job_m, job_n, job_k;
   logic          eng_start, eng_abort, eng_done;
   logic [AW-1:0] eng_a_addr, eng_b_addr, eng_c_addr;
   logic [31:0]   eng_m, eng_n, eng_k;
   logic          cpl_valid, cpl_ready;
   logic [7:0]    cpl_id;
   logic [1:0]    cpl_status;
   logic [31:0]   cpl_cycles;
   logic [2:0]    queue_level;
   logic [31:0]   jobs_completed;

   matrix_job_scheduler #(.QUEUE_DEPTH(QD), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .DIM_ALIGN(DA)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
      .job_a_addr(job_a_addr), .job_b_addr(job_b_addr), .job_c_addr(job_c_addr),
      .job_m(job_m), .job_n(job_n), .job_k(job_k),
      .eng_start(eng_start), .eng_abort(eng_abort),
      .eng_a_addr(eng_a_addr), .eng_b_addr(eng_b_addr), .eng_c_addr(eng_c_addr),
      .eng_m(eng_m), .eng_n(eng_n), .eng_k(eng_k), .eng_done(eng_done),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_id(cpl_id),
      .cpl_status(cpl_status), .cpl_cycles(cpl_cycles),
      .queue_level(queue_level), .jobs_completed(jobs_completed)
   );

   typedef struct {
      logic [7:0]  id;
      logic [63:0] a, b, c;
      logic [31:0] m, n, k;
      logic [1:0]  st;
      int          run_len;
   } exp_t;

   exp_t pend[$];
   int   plan [256];
   int   checks = 0, failures = 0;
   int   n_start = 0, n_abort = 0, jobs_m = 0;
   bit   spur = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Engine stand-in: raises eng_done `plan` cycles after eng_start; 0 or beyond the timeout never finishes.
   initial begin
      int age, dly;
      bit armed;
      armed = 0; age = 0; dly = 0; eng_done = 1'b0;
      forever begin
         @(negedge clk);
         eng_done = 1'b0;
         if (rst) begin
            armed = 0;
            age   = 0;
         end else begin
            if (armed) begin
               age++;
               if (age == dly) begin eng_done = 1'b1; armed = 0; end
            end
            if (eng_start) begin
               dly   = plan[eng_a_addr[15:8]];
               armed = (dly >= 1) && (dly <= TMO);
               age   = 0;
            end
            if (spur) begin eng_done = 1'b1; spur = 0; end
         end
      end
   end

   // Job-level model: each accepted job is launched once (unless its dimensions are bad),
   // runs for its planned length or the timeout, then completes in arrival order.
   initial begin
      int  sample, age, hs_sample;
      bit  active, started, pv, pr;
      logic [7:0] pid;
      sample = 0; age = 0; hs_sample = -100; active = 0; started = 0; pv = 0; pr = 0; pid = '0;
      forever begin
         @(negedge clk);
         #1;
         sample++;
         if (rst) begin
            pend.delete();
            active = 0; started = 0; pv = 0; jobs_m = 0; hs_sample = -100;
         end else begin
            if (active) age++;
            chk("job_ready", job_ready, 64'(queue_level != 3'(QD)));
            chk("jobs_completed", jobs_completed, 64'(jobs_m));
            if (eng_start) begin
               n_start++;
               chk("start_allowed", (pend.size() != 0) && !started && pend[0].st != 2'd1, 1);
               chk("start_gap", (sample - hs_sample) >= 3, 1);
               if (pend.size() != 0) begin started = 1; active = 1; age = 0; end
            end
            if (eng_abort) n_abort++;
            if (active) begin
               chk("eng_a", eng_a_addr, pend[0].a);
               chk("eng_b", eng_b_addr, pend[0].b);
               chk("eng_c", eng_c_addr, pend[0].c);
               chk("eng_m", eng_m, 64'(pend[0].m));
               chk("eng_n", eng_n, 64'(pend[0].n));
               chk("eng_k", eng_k, 64'(pend[0].k));
               chk("eng_abort", eng_abort, 64'(age == TMO && pend[0].st == 2'd2));
               if (age == pend[0].run_len) active = 0;
            end else begin
               chk("eng_abort_idle", eng_abort, 0);
            end
            if (cpl_valid) begin
               if (pend.size() == 0 || active || !(started || pend[0].st == 2'd1)) begin
                  chk("cpl_unexpected", 1, 0);
               end else begin
                  chk("cpl_id", cpl_id, 64'(pend[0].id));
                  chk("cpl_status", cpl_status, 64'(pend[0].st));
                  chk("cpl_cycles", cpl_cycles, PERF ? 64'(pend[0].run_len) : 64'd0);
                  if (pv && !pr) chk("cpl_id_stable", cpl_id, 64'(pid));
                  pid = pend[0].id;
                  if (cpl_ready) begin
                     void'(pend.pop_front());
                     started = 0; jobs_m++; hs_sample = sample;
                  end
               end
            end else if (pv && !pr) begin
               chk("cpl_valid_held", 0, 1);
            end
            pv = cpl_valid;
            pr = cpl_ready;
         end
      end
   end

   // Offers one descriptor from a negedge and returns at the negedge after it is accepted.
   task automatic push_job(input logic [7:0] id, input logic [31:0] m, input logic [31:0] n,
                           input logic [31:0] k, input int dly);
      exp_t e;
      bit   bad;
      plan[id]   = dly;
      job_id     = id;
      job_a_addr = 64'hA000_0000_0000_0000 | {48'h0, id, 8'h00};
      job_b_addr = 64'hB000_0000_0000_0000 | {56'h0, id};
      job_c_addr = 64'hC000_0000_0000_0000 | {56'h0, id};
      job_m = m; job_n = n; job_k = k;
      bad = (m == 0) || (m % DA != 0) || (n == 0) || (n % DA != 0) || (k == 0) || (k % DA != 0);
      e.id = id; e.a = job_a_addr; e.b = job_b_addr; e.c = job_c_addr; e.m = m; e.n = n; e.k = k;
      if (bad)                         begin e.st = 2'd1; e.run_len = 0;   end
      else if (dly >= 1 && dly <= TMO) begin e.st = 2'd0; e.run_len = dly; end
      else                             begin e.st = 2'd2; e.run_len = TMO; end
      job_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (job_ready) begin
            @(posedge clk);
            pend.push_back(e);
            @(negedge clk);
            job_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      job_valid = 1'b0;
      chk("push_timeout", 0, 1);
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (pend.size() == 0 && !cpl_valid) return;
      end
      chk("drain_timeout", 0, 1);
   endtask

   task automatic wait_cpl(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk); #2;
         if (cpl_valid) return;
      end
      chk("cpl_wait_timeout", 0, 1);
   endtask

   task automatic chk_reset_state();
      chk("rst_job_ready", job_ready, 1);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_abort", eng_abort, 0);
      chk("rst_eng_a", eng_a_addr, 0);
      chk("rst_eng_m", {eng_m, eng_n}, 0);
      chk("rst_eng_k", eng_k, 0);
      chk("rst_cpl_valid", cpl_valid, 0);
      chk("rst_cpl_fields", {cpl_id, cpl_status, cpl_cycles}, 0);
      chk("rst_queue_level", queue_level, 0);
      chk("rst_jobs_completed", jobs_completed, 0);
   endtask

   initial begin
      int s, ns, na, jc;
      rst = 1'b1; job_valid = 1'b0; cpl_ready = 1'b1;
      job_id = '0; job_a_addr = '0; job_b_addr = '0; job_c_addr = '0;
      job_m = '0; job_n = '0; job_k = '0;
      for (int i = 0; i < 256; i++) plan[i] = 0;
      repeat (3) @(negedge clk);
      #2 chk_reset_state();
      @(negedge clk) rst = 1'b0;

      // Single job, completion held off for 20 cycles while a second job waits.
      cpl_ready = 1'b0;
      push_job(8'd5, 32'd64, 32'd64, 32'd64, 100);
      #2 chk("lat_s1_no_start", eng_start, 0);
      @(negedge clk); #2 chk("lat_s2_no_start", eng_start, 0);
      @(negedge clk); #2 chk("pop_to_start", eng_start, 1);
      chk("start_m", eng_m, 64);
      chk("start_a", eng_a_addr, 64'hA000_0000_0000_0500);
      @(negedge clk);
      push_job(8'd6, 32'd8, 32'd16, 32'd24, 10);
      wait_cpl(200);
      chk("job5_id", cpl_id, 5);
      chk("job5_status", cpl_status, 0);
      chk("job5_cycles", cpl_cycles, PERF ? 64'd100 : 64'd0);
      ns = n_start;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #2;
         chk("stall_valid", cpl_valid, 1);
         chk("stall_id", cpl_id, 5);
         chk("stall_jobs", jobs_completed, 0);
      end
      chk("stall_no_start", n_start, ns);
      chk("stall_level", queue_level, 1);
      @(negedge clk) cpl_ready = 1'b1;
      @(negedge clk); #2 chk("job5_counted", jobs_completed, 1);
      wait_drain(200);
      chk("after_t1_jobs", jobs_completed, 2);

      // Back-to-back pushes while the engine is busy fill the queue.
      @(negedge clk);
      for (int i = 0; i < 6; i++) plan[i] = 20;
      for (int i = 0; i < 5; i++) push_job(8'(i), 32'd32, 32'd32, 32'd32, 20);
      #2;
      chk("full_level", queue_level, 4);
      chk("full_ready", job_ready, 0);
      @(negedge clk);
      push_job(8'd5, 32'd16, 32'd8, 32'd8, 20);
      wait_drain(1000);
      chk("after_t2_jobs", jobs_completed, 8);

      // Bad dimensions complete without an engine launch.
      @(negedge clk);
      ns = n_start;
      push_job(8'h20, 32'd64, 32'd64, 32'd60, 10);
      s = 1;
      #2;
      while (!cpl_valid && s < 6) begin @(negedge clk); #2; s++; end
      chk("bad_latency_le3", s <= 3, 1);
      chk("bad_status", cpl_status, 1);
      chk("bad_cycles", cpl_cycles, 0);
      @(negedge clk);
      push_job(8'h21, 32'd0, 32'd8, 32'd8, 10);
      push_job(8'h22, 32'd8, 32'd12, 32'd8, 10);
      wait_drain(100);
      chk("bad_no_start", n_start, ns);

      // Timeout, then a normal job, then a done landing exactly on the timeout cycle.
      @(negedge clk);
      na = n_abort;
      cpl_ready = 1'b0;
      push_job(8'h30, 32'd8, 32'd8, 32'd8, 0);
      wait_cpl(TMO + 20);
      chk("tmo_status", cpl_status, 2);
      chk("tmo_cycles", cpl_cycles, PERF ? 64'(TMO) : 64'd0);
      chk("tmo_abort_count", n_abort - na, 1);
      @(negedge clk) cpl_ready = 1'b1;
      push_job(8'h31, 32'd8, 32'd8, 32'd8, 5);
      push_job(8'h32, 32'd8, 32'd8, 32'd8, TMO);
      wait_drain(600);
      chk("tie_no_abort", n_abort - na, 1);

      // A done pulse while idle is ignored.
      ns = n_start; jc = int'(jobs_completed);
      @(negedge clk) spur = 1;
      repeat (5) @(negedge clk);
      #2;
      chk("spur_no_cpl", cpl_valid, 0);
      chk("spur_no_start", n_start, ns);
      chk("spur_jobs", jobs_completed, 64'(jc));

      // Reset while a job runs with another queued.
      @(negedge clk);
      push_job(8'h40, 32'd8, 32'd8, 32'd8, 0);
      push_job(8'h41, 32'd8, 32'd8, 32'd8, 5);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      na = n_abort;
      @(negedge clk); #2 chk_reset_state();
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #2;
         chk("post_rst_no_cpl", cpl_valid, 0);
      end
      chk("post_rst_no_abort", n_abort, na);
      @(negedge clk);
      push_job(8'h42, 32'd8, 32'd8, 32'd8, 7);
      wait_drain(100);
      chk("post_rst_jobs", jobs_completed, 1);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/matrix_job_scheduler.md
Name: matrix_job_scheduler

Overview:
Queues matrix-multiply job descriptors and sequences them one at a time into the shared matrix-multiply engine. Drives the engine's address, dimension and start fields and waits for its done pulse. Each job returns a completion record with an ID and status. Sits between the host control-register / TCP-metadata path and the matrix engine's control inputs.

Parameters:
QUEUE_DEPTH, 4, job descriptor FIFO entries (power of 2, ≥2)
ADDR_WIDTH, 64, byte address width of the A/B/C operand pointers
TIMEOUT_CYCLES, 1048576, maximum engine run cycles before a job is aborted
DIM_ALIGN, 8, required multiple for m/n/k (8 x 32-bit words per 256-bit beat)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
job_valid  in  1  descriptor offered
job_ready  out  1  queue not full
job_id  in  8  tag echoed in completion
job_a_addr / job_b_addr / job_c_addr  in  ADDR_WIDTH each  operand and result base addresses
job_m / job_n / job_k  in  32 each  matrix dimensions
eng_start  out  1  one-cycle launch pulse to engine
eng_abort  out  1  one-cycle abort pulse on timeout
eng_a_addr / eng_b_addr / eng_c_addr  out  ADDR_WIDTH each  held stable from eng_start until done/abort
eng_m / eng_n / eng_k  out  32 each  held stable, same window
eng_done  in  1  one-cycle pulse, engine finished
cpl_valid  out  1  completion record valid
cpl_ready  in  1  completion consumer ready
cpl_id  out  8  tag of the completed job
cpl_status  out  2  0=OK, 1=BAD_DIM, 2=TIMEOUT, 3=reserved
cpl_cycles  out  32  cycles from eng_start to done (see optional feature)
queue_level  out  $clog2(QUEUE_DEPTH)+1  occupied FIFO entries
jobs_completed  out  32  completions accepted by consumer, wraps at 2^32

Behaviour:
- Reset: all outputs 0 except job_ready=1. FIFO emptied, FSM→IDLE, counters cleared. Reset mid-job drops the job with no completion and no eng_abort.
- Enqueue on job_valid&&job_ready. job_ready=0 when queue_level==QUEUE_DEPTH.
- Simultaneous push and pop: queue_level unchanged. A push into an empty FIFO is visible to IDLE next cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into working registers → CHECK.
  - CHECK: if any of m/n/k is 0 or not a multiple of DIM_ALIGN, set status=BAD_DIM → CPL (engine never started). Otherwise → LAUNCH.
  - LAUNCH: drive eng_* fields, assert eng_start for exactly 1 cycle, clear timer → RUN.
  - RUN: timer increments each cycle.
    - eng_done → status=OK → CPL.
    - timer==TIMEOUT_CYCLES-1 without done → eng_abort 1 cycle, status=TIMEOUT → CPL.
    - eng_done in the same cycle as the timeout wins: OK.
  - CPL: cpl_valid=1, fields stable until cpl_ready. On handshake, jobs_completed++ → IDLE.
- eng_done outside RUN is ignored.
- Minimum latency, pop → eng_start: 2 cycles (IDLE→CHECK→LAUNCH).
- Back-to-back jobs: the next eng_start occurs no earlier than 3 cycles after the previous completion handshake.
- cpl_valid never deasserts without cpl_ready (AXI-stream rule).

Optional Feature:
MATRIX_SCHED_PERF_EN:
- Defined: cpl_cycles = RUN-state cycle count for the job (saturating at 32'hFFFFFFFF). BAD_DIM jobs report 0.
- Undefined: cpl_cycles tied to 0 and the counter logic is removed. All other behaviour is identical.

Test Plan:
- Single job id=5, m=n=k=64, eng_done 100 cycles after eng_start → one eng_start pulse, eng_* match the descriptor, cpl id=5 status=0, cpl_cycles=100 with PERF_EN, jobs_completed=1.
- Push 5 jobs back-to-back with the engine stalled → job_ready drops after 4th accept (queue_level=4), 5th held; after the first done, job_ready returns and all 5 complete in order with ids 0..4.
- Job with k=60 → no eng_start, cpl status=1 within 3 cycles of pop.
- Job with TIMEOUT_CYCLES=16, no eng_done → eng_abort pulse on the 16th RUN cycle, cpl status=2. A following valid job launches normally.
- cpl_ready held low 20 cycles → cpl fields stable, no new eng_start, jobs_completed unchanged until the handshake.
- Assert rst during RUN → all outputs back to reset values next cycle, no completion emitted, queue_level=0.
